// File: rtl/serial_bit_tx_pkg.sv
// Shared types and helpers for the serial_bit_tx transmitter.
package serial_bit_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    GAP    = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  // Bits needed to hold any value in 0..width.
  function automatic int calc_len_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Running even-parity accumulator step.
  function automatic logic par_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/serial_bit_tx_cnt.sv
// Loadable down-counter with zero flag; shared by the bit and gap phases of serial_bit_tx.
module serial_bit_tx_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Counter register: clear beats load beats decrement; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/serial_bit_tx.sv
// Serial bit-stream transmitter: shifts a loaded word out LSB-first, then idles for GAP_CYCLES.
// Build option SERIAL_BIT_TX_PARITY_EN appends one even-parity bit after each non-empty word.
module serial_bit_tx
  import serial_bit_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
  parameter int   LEN_W      = calc_len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             abort,
  output logic             a,
  output logic             busy,
  output logic             done
);

  localparam int               GAP_W    = calc_len_w(GAP_CYCLES);
  localparam int               CNT_W    = (LEN_W > GAP_W) ? LEN_W : GAP_W;
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_r, state_nx_s;
  logic             a_r, a_nx_s;
  logic             done_r, done_nx_s;
  logic             par_r, par_nx_s;
  logic [WIDTH-1:0] sh_r, sh_nx_s;
  logic [LEN_W-1:0] len_s;
  logic             cnt_clr_s, cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CNT_W-1:0] cnt_val_s;
  state_t           end_state_s;

  assign len_s       = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
  assign end_state_s = HAS_GAP ? GAP : IDLE;

  serial_bit_tx_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and datapath decode; the counter holds bits remaining after the one on `a`.
  always_comb begin
    state_nx_s = state_r;
    a_nx_s     = IDLE_LEVEL;
    done_nx_s  = 1'b0;
    par_nx_s   = par_r;
    sh_nx_s    = sh_r;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_val_s  = '0;
    case (state_r)
      IDLE: begin
        if (load_valid) begin
          sh_nx_s = load_data >> 1'b1;
          if (len_s != '0) begin
            state_nx_s = SEND;
            a_nx_s     = load_data[0];
            par_nx_s   = load_data[0];
            cnt_load_s = 1'b1;
            cnt_val_s  = CNT_W'(len_s - LEN_W'(1'b1));
          end else begin
            state_nx_s = end_state_s;
            done_nx_s  = ~HAS_GAP;
            cnt_load_s = HAS_GAP;
            cnt_val_s  = GAP_LOAD;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      SEND: begin
        if (abort) begin
          state_nx_s = IDLE;
          cnt_clr_s  = 1'b1;
        end else if (!cnt_zero_s) begin
          a_nx_s    = sh_r[0];
          sh_nx_s   = sh_r >> 1'b1;
          par_nx_s  = par_step(par_r, sh_r[0]);
          cnt_dec_s = 1'b1;
        end else begin
`ifdef SERIAL_BIT_TX_PARITY_EN
          state_nx_s = PARITY;
          a_nx_s     = par_r;
`else
          state_nx_s = end_state_s;
          done_nx_s  = ~HAS_GAP;
          cnt_load_s = HAS_GAP;
          cnt_val_s  = GAP_LOAD;
`endif
        end
      end
`ifdef SERIAL_BIT_TX_PARITY_EN
      PARITY: begin
        if (abort) begin
          state_nx_s = IDLE;
          cnt_clr_s  = 1'b1;
        end else begin
          state_nx_s = end_state_s;
          done_nx_s  = ~HAS_GAP;
          cnt_load_s = HAS_GAP;
          cnt_val_s  = GAP_LOAD;
        end
      end
`endif
      GAP: begin
        if (abort) begin
          state_nx_s = IDLE;
          cnt_clr_s  = 1'b1;
        end else if (cnt_zero_s) begin
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_clr_s  = 1'b1;
      end
    endcase
  end

  // Registered serial bit, done pulse, shift register and parity accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= IDLE_LEVEL;
      done_r <= 1'b0;
      par_r  <= 1'b0;
      sh_r   <= '0;
    end else begin
      a_r    <= a_nx_s;
      done_r <= done_nx_s;
      par_r  <= par_nx_s;
      sh_r   <= sh_nx_s;
    end
  end

  assign a          = a_r;
  assign done       = done_r;
  assign load_ready = (state_r == IDLE);
  assign busy       = (state_r != IDLE);

endmodule
